// File: rtl/inpkt_config_mux.sv
// Two-subtype configuration packet receiver: subtype byte + little-endian payload, atomic commit.
// Optional INPKT_CONFIG_RECOVER_EN: recoverable errors with DRAIN; otherwise errors are sticky until RST.
module inpkt_config_mux #(
  parameter int SUBTYPE1_WIDTH = 32,
  parameter int SUBTYPE2_WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [7:0]                din,
  input  logic                      wr_en,
  input  logic                      pkt_end,
  output logic                      full,
  output logic [SUBTYPE1_WIDTH-1:0] dout1,
  output logic                      dout1_valid,
  output logic [SUBTYPE2_WIDTH-1:0] dout2,
  output logic                      dout2_valid,
  output logic                      err,
  output logic [1:0]                err_code
);

  localparam int N1      = (SUBTYPE1_WIDTH + 7) / 8;
  localparam int N2      = (SUBTYPE2_WIDTH + 7) / 8;
  localparam int NMAX    = (N1 > N2) ? N1 : N2;
  localparam int CNT_W   = $clog2(NMAX + 1);
  localparam int STAGE_W = 8 * NMAX;

  localparam logic [CNT_W-1:0] N1_C = CNT_W'(N1);
  localparam logic [CNT_W-1:0] N2_C = CNT_W'(N2);

  typedef enum logic [2:0] {
    ST_SUBTYPE,
    ST_DATA1,
    ST_DATA2,
`ifdef INPKT_CONFIG_RECOVER_EN
    ST_DRAIN
`else
    ST_ERROR
`endif
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_SUBTYPE = 2'd1,
    ERR_LONG    = 2'd2,
    ERR_SHORT   = 2'd3
  } err_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [STAGE_W-1:0]        stage_q, stage_d;
  logic [SUBTYPE1_WIDTH-1:0] dout1_q, dout1_d;
  logic [SUBTYPE2_WIDTH-1:0] dout2_q, dout2_d;
  logic                      dout1_valid_q, dout1_valid_d;
  logic                      dout2_valid_q, dout2_valid_d;
  logic                      err_q, err_d;
  err_e                      err_code_q, err_code_d;

  logic                      fault;
  err_e                      fault_code;
  logic [CNT_W-1:0]          n_cur;

  // NOTE: combinational next-state logic uses blocking '=' with a default for every
  // variable up front, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stage_d       = stage_q;
    dout1_d       = dout1_q;
    dout2_d       = dout2_q;
    dout1_valid_d = 1'b0;
    dout2_valid_d = 1'b0;
    err_code_d    = err_code_q;
`ifdef INPKT_CONFIG_RECOVER_EN
    err_d         = 1'b0;
`else
    err_d         = err_q;
`endif
    fault         = 1'b0;
    fault_code    = ERR_NONE;
    n_cur         = (state_q == ST_DATA1) ? N1_C : N2_C;

    if (wr_en) begin
      unique case (state_q)
        ST_SUBTYPE: begin
          cnt_d = '0;
          // An empty payload is reported before the subtype is looked at.
          if (pkt_end) begin
            fault      = 1'b1;
            fault_code = ERR_SHORT;
          end else if (din == 8'd1) begin
            state_d = ST_DATA1;
          end else if (din == 8'd2) begin
            state_d = ST_DATA2;
          end else begin
            fault      = 1'b1;
            fault_code = ERR_SUBTYPE;
          end
        end

        ST_DATA1, ST_DATA2: begin
          if (cnt_q == n_cur) begin
            fault      = 1'b1;
            fault_code = ERR_LONG;
          end else begin
            for (int k = 0; k < NMAX; k++) begin
              if (cnt_q == CNT_W'(k)) stage_d[8*k +: 8] = din;
            end
            cnt_d = cnt_q + 1'b1;
            if (pkt_end) begin
              if (cnt_d == n_cur) begin
                if (state_q == ST_DATA1) begin
                  dout1_d       = stage_d[SUBTYPE1_WIDTH-1:0];
                  dout1_valid_d = 1'b1;
                end else begin
                  dout2_d       = stage_d[SUBTYPE2_WIDTH-1:0];
                  dout2_valid_d = 1'b1;
                end
                state_d = ST_SUBTYPE;
              end else begin
                fault      = 1'b1;
                fault_code = ERR_SHORT;
              end
            end
          end
        end

`ifdef INPKT_CONFIG_RECOVER_EN
        ST_DRAIN: begin
          if (pkt_end) state_d = ST_SUBTYPE;
        end
`else
        ST_ERROR: ;
`endif

        default: ;
      endcase
    end

    if (fault) begin
      err_d      = 1'b1;
      err_code_d = fault_code;
`ifdef INPKT_CONFIG_RECOVER_EN
      state_d    = pkt_end ? ST_SUBTYPE : ST_DRAIN;
`else
      state_d    = ST_ERROR;
`endif
    end
  end

  // NOTE: the staging register is reset along with the rest of the state; it is small
  // and a clean reset value keeps post-reset behaviour fully deterministic.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_SUBTYPE;
      cnt_q         <= '0;
      stage_q       <= '0;
      dout1_q       <= '0;
      dout2_q       <= '0;
      dout1_valid_q <= 1'b0;
      dout2_valid_q <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stage_q       <= stage_d;
      dout1_q       <= dout1_d;
      dout2_q       <= dout2_d;
      dout1_valid_q <= dout1_valid_d;
      dout2_valid_q <= dout2_valid_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
    end
  end

  assign full        = 1'b0;
  assign dout1       = dout1_q;
  assign dout1_valid = dout1_valid_q;
  assign dout2       = dout2_q;
  assign dout2_valid = dout2_valid_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_inpkt_config_mux.sv
// Directed bench for inpkt_config_mux: default widths plus a SUBTYPE1_WIDTH=12 instance on shared inputs.
module tb_inpkt_config_mux;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  din;
  logic        wr_en;
  logic        pkt_end;

  logic        full, dout1_valid, dout2_valid, err;
  logic [31:0] dout1;
  logic [15:0] dout2;
  logic [1:0]  err_code;

  logic        full_b, dout1_valid_b, dout2_valid_b, err_b;
  logic [11:0] dout1_b;
  logic [15:0] dout2_b;
  logic [1:0]  err_code_b;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  inpkt_config_mux dut (
    .CLK(CLK), .RST(RST), .din(din), .wr_en(wr_en), .pkt_end(pkt_end),
    .full(full), .dout1(dout1), .dout1_valid(dout1_valid),
    .dout2(dout2), .dout2_valid(dout2_valid), .err(err), .err_code(err_code)
  );

  inpkt_config_mux #(.SUBTYPE1_WIDTH(12), .SUBTYPE2_WIDTH(16)) dut12 (
    .CLK(CLK), .RST(RST), .din(din), .wr_en(wr_en), .pkt_end(pkt_end),
    .full(full_b), .dout1(dout1_b), .dout1_valid(dout1_valid_b),
    .dout2(dout2_b), .dout2_valid(dout2_valid_b), .err(err_b), .err_code(err_code_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one byte at a falling edge; returns at the next falling edge, after it was sampled.
  task automatic put(input logic [7:0] b, input logic e);
    din = b; wr_en = 1'b1; pkt_end = e;
    @(negedge CLK);
  endtask

  task automatic idle();
    wr_en = 1'b0; pkt_end = 1'b0;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1; wr_en = 1'b0; pkt_end = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    din = 8'h00; wr_en = 1'b0; pkt_end = 1'b0; RST = 1'b1;
    @(negedge CLK);
    do_reset();

    check("rst_dout1", 64'(dout1), 64'h0);
    check("rst_dout2", 64'(dout2), 64'h0);
    check("rst_valids", {62'b0, dout1_valid, dout2_valid}, 64'h0);
    check("rst_err", 64'(err), 64'h0);
    check("rst_err_code", 64'(err_code), 64'h0);
    check("full_zero", 64'(full), 64'h0);

    // Subtype 1, 4-byte little-endian payload.
    put(8'h01, 0); put(8'h78, 0); put(8'h56, 0); put(8'h34, 0);
    check("p1_no_early_valid", 64'(dout1_valid), 64'h0);
    put(8'h12, 1);
    check("p1_dout1", 64'(dout1), 64'h12345678);
    check("p1_valid", 64'(dout1_valid), 64'h1);
    check("p1_err", 64'(err), 64'h0);
    idle();
    check("p1_valid_one_cycle", 64'(dout1_valid), 64'h0);
    check("p1_dout1_held", 64'(dout1), 64'h12345678);

    // Subtype 2 followed back-to-back by subtype 1.
    put(8'h02, 0); put(8'hCD, 0); put(8'hAB, 1);
    check("p2_dout2", 64'(dout2), 64'hABCD);
    check("p2_valid", 64'(dout2_valid), 64'h1);
    check("p2_no_v1", 64'(dout1_valid), 64'h0);
    put(8'h01, 0);
    check("p2_valid_drop", 64'(dout2_valid), 64'h0);
    put(8'h11, 0); put(8'h22, 0); put(8'h33, 0); put(8'h44, 1);
    check("b2b_dout1", 64'(dout1), 64'h44332211);
    check("b2b_valid", 64'(dout1_valid), 64'h1);
    check("b2b_err", 64'(err), 64'h0);

    // Idle cycles inside a packet hold state and counter.
    put(8'h02, 0); idle(); put(8'hEF, 0); idle(); idle(); put(8'hBE, 1);
    check("gap_dout2", 64'(dout2), 64'hBEEF);
    check("gap_valid", 64'(dout2_valid), 64'h1);

    // Short subtype-1 payload.
    put(8'h01, 0); put(8'hAA, 0); put(8'hBB, 0); put(8'hCC, 1);
    check("short_err", 64'(err), 64'h1);
    check("short_code", 64'(err_code), 64'h3);
    check("short_dout1", 64'(dout1), 64'h44332211);
    check("short_no_valid", 64'(dout1_valid), 64'h0);
    idle();
`ifdef INPKT_CONFIG_RECOVER_EN
    check("short_err_pulse", 64'(err), 64'h0);
`else
    check("short_err_sticky", 64'(err), 64'h1);
`endif
    check("short_code_held", 64'(err_code), 64'h3);

    do_reset();
    check("rst2_err", 64'(err), 64'h0);
    check("rst2_code", 64'(err_code), 64'h0);
    check("rst2_dout1", 64'(dout1), 64'h0);

    // Long subtype-1 payload: fifth byte is the error.
    put(8'h01, 0); put(8'h01, 0); put(8'h02, 0); put(8'h03, 0); put(8'h04, 0);
    check("long_wait_no_err", 64'(err), 64'h0);
    check("long_wait_no_valid", 64'(dout1_valid), 64'h0);
    put(8'h05, 1);
    check("long_err", 64'(err), 64'h1);
    check("long_code", 64'(err_code), 64'h2);
    check("long_dout1", 64'(dout1), 64'h0);
    check("long_no_valid", 64'(dout1_valid), 64'h0);

    do_reset();
    // Unsupported subtype, then a good subtype-2 packet.
    put(8'h07, 0);
    check("bad_sub_err", 64'(err), 64'h1);
    check("bad_sub_code", 64'(err_code), 64'h1);
    put(8'hAA, 0);
`ifdef INPKT_CONFIG_RECOVER_EN
    check("bad_sub_pulse", 64'(err), 64'h0);
`else
    check("bad_sub_sticky", 64'(err), 64'h1);
`endif
    put(8'hBB, 1);
    put(8'h02, 0); put(8'h34, 0); put(8'h12, 1);
`ifdef INPKT_CONFIG_RECOVER_EN
    check("recover_dout2", 64'(dout2), 64'h1234);
    check("recover_valid", 64'(dout2_valid), 64'h1);
    check("recover_err", 64'(err), 64'h0);
`else
    check("locked_dout2", 64'(dout2), 64'h0);
    check("locked_valid", 64'(dout2_valid), 64'h0);
    check("locked_err", 64'(err), 64'h1);
`endif
    check("bad_sub_code_held", 64'(err_code), 64'h1);

    do_reset();
    check("rst3_err", 64'(err), 64'h0);
    // Subtype byte with pkt_end: empty payload.
    put(8'h01, 1);
    check("empty_err", 64'(err), 64'h1);
    check("empty_code", 64'(err_code), 64'h3);

    do_reset();
    // 12-bit subtype-1 instance: two bytes, top nibble of the last byte discarded.
    put(8'h01, 0); put(8'hFF, 0); put(8'hFF, 1);
    check("w12_dout1", 64'(dout1_b), 64'hFFF);
    check("w12_valid", 64'(dout1_valid_b), 64'h1);
    check("w12_err", 64'(err_b), 64'h0);
    check("w32_short_code", 64'(err_code), 64'h3);

    // Reset mid-packet; the byte presented with RST is dropped.
    put(8'h01, 0); put(8'h11, 0);
    RST = 1'b1; din = 8'h01; wr_en = 1'b1; pkt_end = 1'b0;
    @(negedge CLK);
    RST = 1'b0; wr_en = 1'b0;
    check("mid_rst_dout1", 64'(dout1_b), 64'h0);
    check("mid_rst_err", 64'(err_b), 64'h0);
    check("mid_rst_err32", 64'(err), 64'h0);
    check("mid_rst_code32", 64'(err_code), 64'h0);
    put(8'h02, 0); put(8'hCD, 0); put(8'hAB, 1);
    check("post_rst_dout2", 64'(dout2_b), 64'hABCD);
    check("post_rst_valid", 64'(dout2_valid_b), 64'h1);
    check("post_rst_dout1", 64'(dout1_b), 64'h0);
    check("post_rst_dout2_32", 64'(dout2), 64'hABCD);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
